// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared types and helpers for the bit-serial subtractor.
//   state_e   : controller states {IDLE, RUN, DONE}, 2-bit encoding
//   cnt_width : bit counter width for a given operand width ($clog2, min 1)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_subtractor_1b.sv
// -----------------------------------------------------------------------------
// full_subtractor_1b
// One-bit full subtractor, purely combinational: d = a - b - bin.
// Ports:
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
// -----------------------------------------------------------------------------
module full_subtractor_1b (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor z = m - n, LSB first, one bit per clock,
// with a start/done handshake. The result is held until the next one completes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, honoured in IDLE or DONE only
//   m, n       : unsigned minuend / subtrahend, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when z/borrow become valid
//   z          : m - n mod 2^WIDTH
//   borrow     : 1 iff m < n (unsigned)
//   ovf        : two's-complement overflow of m - n (only with
//                SERIAL_SUBTRACTOR_OVF_EN defined)
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic [1:0]       msb_q, msb_d;     // {m[MSB], n[MSB]} as captured
    logic             ovf_q, ovf_d;
`endif

    logic diff;
    logic bout;

    full_subtractor_1b u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_q),
        .d    (diff),
        .bout (bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        bin_d    = bin_q;
        z_d      = z_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        msb_d    = msb_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = m;
                    b_d     = n;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    msb_d   = {m[WIDTH-1], n[WIDTH-1]};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Difference bits enter at the MSB so that after WIDTH shifts
                // bit 0 has arrived at position 0.
                acc_d = {diff, acc_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Outputs change only here, so no partial result is ever visible.
                    z_d      = {diff, acc_q[WIDTH-1:1]};
                    borrow_d = bout;
                    state_d  = DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // diff is the MSB of the final result on this edge.
                    ovf_d    = (msb_q[1] ^ msb_q[0]) & (msb_q[1] ^ diff);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            bin_q    <= 1'b0;
            z_q      <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            msb_q    <= 2'b00;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            bin_q    <= bin_d;
            z_q      <= z_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            msb_q    <= msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign z      = z_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=4). A transaction-level
// model predicts busy/done/z/borrow(/ovf) every cycle; directed operations
// add literal expectations. Define SERIAL_SUBTRACTOR_OVF_EN to cover ovf.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] m = '0;
    logic [W-1:0] n = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] z;
    logic         borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .m      (m),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .z      (z),
        .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // An operation accepted on some edge finishes W edges later; until then
    // it is in flight and further starts are ignored.
    int           remaining = 0;
    logic [W-1:0] exp_z = '0, pend_z = '0;
    logic         exp_b = 1'b0, pend_b = 1'b0;
    logic         exp_o = 1'b0, pend_o = 1'b0;
    logic         exp_done = 1'b0;

    always @(posedge clk) begin
        int d, sd;
        if (rst) begin
            remaining = 0;
            exp_z     = '0;
            exp_b     = 1'b0;
            exp_o     = 1'b0;
            exp_done  = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    exp_z    = pend_z;
                    exp_b    = pend_b;
                    exp_o    = pend_o;
                    exp_done = 1'b1;
                end
            end else if (start) begin
                remaining = W;
                d      = int'(m) - int'(n);
                pend_z = d[W-1:0];
                pend_b = (m < n);
                sd     = int'($signed(m)) - int'($signed(n));
                pend_o = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
            end
        end
        #1;
        chk("model_busy", busy, (remaining > 0));
        chk("model_done", done, exp_done);
        chk("model_z", z, exp_z);
        chk("model_borrow", borrow, exp_b);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("model_ovf", ovf, exp_o);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ez, input logic eb, input bit scramble);
        int lat, nbusy;
        @(negedge clk);
        m = a; n = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            m = '0; n = '0;
        end
        lat = 1; nbusy = 0;
        while (!done && lat < 3 * W + 10) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, W + 1);
        chk("busy_cycles", nbusy, W);
        chk("z", z, ez);
        chk("borrow", borrow, eb);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_z", z, 0);
        chk("reset_borrow", borrow, 1'b0);

        run_op(4'd9, 4'd3, 4'h6, 1'b0, 1'b0);
        run_op(4'd3, 4'd9, 4'hA, 1'b1, 1'b0);
        run_op(4'd5, 4'd5, 4'h0, 1'b0, 1'b0);
        run_op(4'd0, 4'd1, 4'hF, 1'b1, 1'b0);
        run_op(4'd15, 4'd0, 4'hF, 1'b0, 1'b0);

        // start held high: a result every W+1 cycles
        @(negedge clk);
        m = 4'd12; n = 4'd4; start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3 * (W + 1); i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        start = 1'b0;
        chk("b2b_dones", cnt, 3);
        chk("b2b_z", z, 4'h8);
        repeat (2) @(negedge clk);

        // start pulse during RUN is ignored
        m = 4'd12; n = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0; m = 4'd1; n = 4'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("run_start_dones", cnt, 1);
        chk("run_start_z", z, 4'h8);

        // reset on the second RUN edge
        m = 4'd7; n = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_z", z, 0);
        chk("midrst_borrow", borrow, 1'b0);
        run_op(4'd7, 4'd2, 4'h5, 1'b0, 1'b0);

        // operands change right after capture
        run_op(4'd10, 4'd4, 4'h6, 1'b0, 1'b1);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        run_op(4'd8, 4'd1, 4'h7, 1'b0, 1'b0);
        chk("ovf_8_1", ovf, 1'b1);
        run_op(4'd2, 4'd1, 4'h1, 1'b0, 1'b0);
        chk("ovf_2_1", ovf, 1'b0);
        run_op(4'd7, 4'd15, 4'h8, 1'b1, 1'b0);
        chk("ovf_7_m1", ovf, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor, z = m - n, one bit per clock, LSB first, with a registered borrow.
- Companion to the team's combinational adder; it provides the inverse operation for datapaths that are area-constrained and latency-tolerant.
- Uses a start/done handshake; the result is held stable until the next accepted start.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- m  input  WIDTH  minuend (unsigned); captured on an accepted start.
- n  input  WIDTH  subtrahend (unsigned); captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- z  output  WIDTH  difference, m - n mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff m < n (unsigned).

Behaviour:
- Reset: state = IDLE; busy, done, borrow, z, bit counter and operand shift registers all cleared to 0.
- Reset has priority over everything, including mid-RUN. The partial result is discarded, and z/borrow go to 0 on the next edge.
- States:
  - IDLE: start=1 -> capture m, n; clear borrow FF; counter=0 -> RUN. Otherwise stay.
  - RUN: busy=1. Each edge handles the current LSBs:
    - diff = a0 ^ b0 ^ bin
    - bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
    - shift diff into the MSB of the result register; shift the operands right; counter++.
    - When counter reaches WIDTH-1 on this edge -> DONE.
  - DONE: done=1 for exactly this cycle. z and borrow hold the final values.
    - start=1 -> accepted back-to-back (same actions as from IDLE) -> RUN.
    - Otherwise -> IDLE.
- start while in RUN is ignored: not queued, no effect on the operation in flight.
- Latency: start sampled on edge E0. Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH. done is high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after start.
- Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- z and borrow:
  - Update only on the final RUN edge, loaded from the internal shift register. No intermediate values are visible on z.
  - They remain stable in IDLE until the next result completes.
- m and n may change freely after the capture edge.
- Width/arithmetic:
  - z wraps modulo 2^WIDTH.
  - borrow is the unsigned underflow indication.
  - m == n gives z=0, borrow=0.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output ovf (1 bit, reset 0), updated together with z.
  - ovf = two's-complement overflow of m - n = (m[MSB] ^ n[MSB]) & (m[MSB] ^ z[MSB]).
  - Computed from the captured MSBs retained in a 2-bit register.
- Not defined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package serial_subtractor_pkg:
  - state enum {IDLE, RUN, DONE} (2 bits)
  - counter width constant computed from WIDTH ($clog2)
- One sub-module, full_subtractor_1b:
  - inputs a, b, bin; outputs d, bout
  - purely combinational
  - instantiated once; its bout feeds the borrow FF

Test Plan:
- WIDTH=4, m=9, n=3, start one cycle -> busy high for 4 cycles; done pulses on edge 5 after start; z=6, borrow=0.
- m=3, n=9 -> z=0xA, borrow=1. Then m=5, n=5 -> z=0, borrow=0. Then m=0, n=1 -> z=0xF, borrow=1.
- start held high continuously with m=12, n=4 -> back-to-back results every 5 cycles, z=8. Pulses of start during RUN produce no extra done.
- rst asserted on edge 2 of RUN (m=7, n=2) -> next edge: busy=0, done=0, z=0, borrow=0, state IDLE. A following start with m=7, n=2 gives z=5.
- Operands changed to m=0, n=0 one cycle after start (original m=10, n=4) -> z=6; capture is confirmed.
- With SERIAL_SUBTRACTOR_OVF_EN: m=8, n=1 -> z=7, ovf=1, borrow=0. m=2, n=1 -> ovf=0.
